// File: rtl/ddr_wr_arbiter_if.sv
// Bundle between the per-channel FIFO read ports, the DDR write-burst master and the arbiter.
// master: the arbiter side; slave: the FIFO/DDR environment side.
interface ddr_wr_arbiter_if #(
    parameter int NCH      = 4,
    parameter int ADDRSIZE = 9,
    parameter int DW       = 128,
    parameter int AW       = 32
);
    localparam int CHW = $clog2(NCH);

    logic [NCH*(ADDRSIZE+1)-1:0] ch_rcount;
    logic [NCH-1:0]              ch_rempty;
    logic [NCH*DW-1:0]           ch_rdata;
    logic [NCH-1:0]              ch_rinc;
    logic [NCH-1:0]              frame_start;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [AW-1:0]               cmd_addr;
    logic [CHW-1:0]              cmd_ch;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [DW-1:0]               wr_data;
    logic                        wr_last;
    logic                        busy;

    modport master (
        input  ch_rcount, ch_rempty, ch_rdata, frame_start, cmd_ready, wr_ready,
        output ch_rinc, cmd_valid, cmd_addr, cmd_ch, wr_valid, wr_data, wr_last, busy
    );

    modport slave (
        output ch_rcount, ch_rempty, ch_rdata, frame_start, cmd_ready, wr_ready,
        input  ch_rinc, cmd_valid, cmd_addr, cmd_ch, wr_valid, wr_data, wr_last, busy
    );
endinterface

// File: rtl/ddr_wr_arbiter.sv
// Round-robin DDR write scheduler: grants a channel holding a full burst, issues the command,
// streams BURST_LEN beats from its FWFT FIFO and advances that channel's frame-buffer offset.
module ddr_wr_arbiter #(
    parameter int            NCH         = 4,
    parameter int            ADDRSIZE    = 9,
    parameter int            DW          = 128,
    parameter int            AW          = 32,
    parameter int            BURST_LEN   = 64,
    parameter logic [AW-1:0] BASE_ADDR   = 32'h0,
    parameter logic [AW-1:0] FRAME_BYTES = 32'h001C_2000
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    ddr_wr_arbiter_if.master      bus
);
    localparam int            CW          = ADDRSIZE + 1;
    localparam int            CHW         = $clog2(NCH);
    localparam int            BPB         = DW / 8;
    localparam int            BW          = $clog2(BURST_LEN + 1);
    localparam logic [AW-1:0] BURST_BYTES = AW'(BURST_LEN * BPB);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t          state, state_nxt;
    logic [CHW-1:0]  rr;
    logic [CHW-1:0]  grant;
    logic [AW-1:0]   cmd_addr_r;
    logic [BW-1:0]   beat;
    logic [NCH-1:0]  pending;
    logic [AW-1:0]   offset [NCH];

    logic [NCH-1:0]  eligible;
    logic            found;
    logic [CHW-1:0]  pick;

    logic            cmd_valid;
    logic            wr_valid;
    logic            wr_last;
    logic            beat_accept;
    logic [NCH-1:0]  ch_rinc;
    logic [DW-1:0]   wr_data;

    // Cyclic search starting at the round-robin pointer.
    always_comb begin
        int unsigned j;
        eligible = '0;
        found    = 1'b0;
        pick     = '0;
        j        = 0;
        for (int unsigned i = 0; i < NCH; i++)
            eligible[i] = (bus.ch_rcount[i*CW +: CW] >= CW'(BURST_LEN));
        for (int unsigned k = 0; k < NCH; k++) begin
            j = 32'(rr) + k;
            if (j >= NCH)
                j = j - NCH;
            if (!found && eligible[j]) begin
                found = 1'b1;
                pick  = CHW'(j);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_valid   = 1'b0;
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        beat_accept = 1'b0;
        ch_rinc     = '0;
        wr_data     = bus.ch_rdata[grant*DW +: DW];
        case (state)
            IDLE: begin
                if (found)
                    state_nxt = CMD;
            end
            CMD: begin
                cmd_valid = 1'b1;
                if (bus.cmd_ready)
                    state_nxt = DATA;
            end
            DATA: begin
                wr_valid       = ~bus.ch_rempty[grant];
                wr_last        = (beat == BW'(BURST_LEN - 1));
                beat_accept    = wr_valid & bus.wr_ready;
                ch_rinc[grant] = beat_accept;
                if (beat_accept && wr_last)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= IDLE;
            rr         <= '0;
            grant      <= '0;
            cmd_addr_r <= '0;
            beat       <= '0;
            pending    <= '0;
            for (int unsigned i = 0; i < NCH; i++)
                offset[i] <= '0;
        end else begin
            state <= state_nxt;
            // A frame restart arriving with the grant uses offset 0 for that very burst.
            if (state == IDLE && found) begin
                grant      <= pick;
                beat       <= '0;
                cmd_addr_r <= BASE_ADDR + AW'(pick) * FRAME_BYTES
                              + (bus.frame_start[pick] ? '0 : offset[pick]);
            end
            if (beat_accept)
                beat <= beat + 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (bus.frame_start[i]) begin
                    if (state == IDLE || CHW'(i) != grant)
                        offset[i] <= '0;
                    else
                        pending[i] <= 1'b1;
                end
            end
            // Later assignments here override the deferred-clear bookkeeping above.
            if (state == DONE) begin
                rr             <= (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
                pending[grant] <= 1'b0;
                if (pending[grant] || bus.frame_start[grant])
                    offset[grant] <= '0;
                else if (offset[grant] + BURST_BYTES == FRAME_BYTES)
                    offset[grant] <= '0;
                else
                    offset[grant] <= offset[grant] + BURST_BYTES;
            end
        end
    end

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_addr  = cmd_addr_r;
    assign bus.cmd_ch    = grant;
    assign bus.wr_valid  = wr_valid;
    assign bus.wr_data   = wr_data;
    assign bus.wr_last   = wr_last;
    assign bus.ch_rinc   = ch_rinc;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter: FIFO model per channel with channel-tagged sequential data,
// plus a small-parameter instance that exercises frame-offset wrap.
module tb_ddr_wr_arbiter;
    logic clk = 1'b0;
    logic rrst_n;
    logic w_rst_n;
    always #5 clk = ~clk;

    ddr_wr_arbiter_if #(.NCH(4), .ADDRSIZE(9), .DW(128), .AW(32)) bus ();
    ddr_wr_arbiter #(
        .NCH(4), .ADDRSIZE(9), .DW(128), .AW(32), .BURST_LEN(64),
        .BASE_ADDR(32'h0), .FRAME_BYTES(32'h001C_2000)
    ) u_dut (
        .rclk(clk), .rrst_n(rrst_n), .bus(bus)
    );

    // Wrap instance: 4 beats x 4 bytes per burst, 4 bursts per frame, ch1 base 0x140.
    ddr_wr_arbiter_if #(.NCH(2), .ADDRSIZE(3), .DW(32), .AW(32)) wbus ();
    ddr_wr_arbiter #(
        .NCH(2), .ADDRSIZE(3), .DW(32), .AW(32), .BURST_LEN(4),
        .BASE_ADDR(32'h100), .FRAME_BYTES(32'h40)
    ) u_wrap (
        .rclk(clk), .rrst_n(w_rst_n), .bus(wbus)
    );
    assign wbus.ch_rcount   = {4'd4, 4'd0};
    assign wbus.ch_rempty   = 2'b00;
    assign wbus.ch_rdata    = {32'h1111_1111, 32'h0};
    assign wbus.frame_start = 2'b00;
    assign wbus.cmd_ready   = 1'b1;
    assign wbus.wr_ready    = 1'b1;

    int          tests = 0;
    int          failed = 0;
    int          supply [4] = '{default: 0};
    int          popped [4] = '{default: 0};
    int          acc [4] = '{default: 0};
    logic [3:0]  hole = '0;
    logic        ready_mode = 1'b0;
    logic        tog = 1'b0;
    int          viol = 0;
    int          data_err = 0;
    int          last_err = 0;
    int          cur_beats = 0;
    logic [31:0] cmd_addr_q [$];
    int          cmd_ch_q [$];
    int          len_q [$];
    logic [31:0] w_addr_q [$];

    // FIFO model: content of channel i is {i, A5A50000, sequence number}.
    always @(posedge clk) begin
        tog <= ~tog;
        for (int i = 0; i < 4; i++)
            if (bus.ch_rinc[i]) popped[i] <= popped[i] + 1;
    end

    always_comb begin
        int a;
        a = 0;
        bus.ch_rcount = '0;
        bus.ch_rempty = '0;
        bus.ch_rdata  = '0;
        for (int i = 0; i < 4; i++) begin
            a = supply[i] - popped[i];
            bus.ch_rcount[i*10 +: 10] = 10'(a);
            bus.ch_rempty[i] = (a == 0) | hole[i];
            bus.ch_rdata[i*128 +: 128] = {32'(i), 32'hA5A5_0000, 64'(popped[i])};
        end
    end

    assign bus.wr_ready = ready_mode ? tog : 1'b1;

    always @(negedge clk) begin
        if (!rrst_n) begin
            cur_beats = 0;
            for (int i = 0; i < 4; i++) acc[i] = popped[i];
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.ch_rinc[i] && (int'(bus.cmd_ch) != i || !bus.wr_valid || !bus.wr_ready || bus.ch_rempty[i]))
                    viol++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_addr_q.push_back(bus.cmd_addr);
                cmd_ch_q.push_back(int'(bus.cmd_ch));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (bus.wr_data !== {32'(bus.cmd_ch), 32'hA5A5_0000, 64'(acc[bus.cmd_ch])}) data_err++;
                if (bus.wr_last !== (cur_beats == 63)) last_err++;
                acc[bus.cmd_ch]++;
                cur_beats++;
                if (bus.wr_last) begin
                    len_q.push_back(cur_beats);
                    cur_beats = 0;
                end
            end
        end
    end

    always @(negedge clk)
        if (w_rst_n && wbus.cmd_valid && wbus.cmd_ready) w_addr_q.push_back(wbus.cmd_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bursts(input int n, input string tag);
        int c;
        c = 0;
        while (len_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(len_q.size() >= n), 64'd1);
    endtask

    task automatic wait_cmds(input int n, input string tag);
        int c;
        c = 0;
        while (cmd_addr_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(cmd_addr_q.size() >= n), 64'd1);
    endtask

    initial begin
        int b;
        int p0;
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        rrst_n = 1'b0;
        w_rst_n = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.frame_start = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valids", {bus.cmd_valid, bus.wr_valid, bus.wr_last}, 3'b000);
        chk("rst_rinc", bus.ch_rinc, 4'h0);
        chk("rst_cmd", {bus.cmd_addr, 30'(bus.cmd_ch)}, 64'h0);
        step();
        rrst_n = 1'b1;
        w_rst_n = 1'b1;

        // Single channel, command held while cmd_ready is low.
        step();
        supply[0] = 64;
        @(negedge clk);
        chk("arb_latency_idle", bus.cmd_valid, 1'b0);
        @(negedge clk);
        chk("cmd_valid", bus.cmd_valid, 1'b1);
        chk("cmd0_addr", bus.cmd_addr, 32'h0);
        chk("cmd0_ch", bus.cmd_ch, 2'd0);
        repeat (2) @(negedge clk);
        chk("cmd_hold", {bus.cmd_valid, bus.cmd_addr}, {1'b1, 32'h0});
        step();
        bus.cmd_ready = 1'b1;
        wait_bursts(1, "t1_burst_done");
        chk("t1_len", len_q[0], 64);
        step();
        supply[0] = 128;
        wait_bursts(2, "t1_second_done");
        chk("t1_second_addr", cmd_addr_q[1], 32'h400);
        chk("t1_data_order", data_err, 0);
        chk("t1_last_pos", last_err, 0);

        chk("wrap_count", 64'(w_addr_q.size() >= 5), 64'd1);
        chk("wrap_first", w_addr_q[0], 32'h140);
        chk("wrap_last_in_frame", w_addr_q[3], 32'h170);
        chk("wrap_back", w_addr_q[4], 32'h140);

        // Round robin from a fresh reset with all channels eligible.
        step();
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        b = cmd_addr_q.size();
        supply[0] += 128;
        for (int i = 1; i < 4; i++) supply[i] += 64;
        wait_bursts(7, "t2_done");
        for (int k = 0; k < 5; k++) chk("rr_order", cmd_ch_q[b+k], exp_ch[k]);
        chk("rr_ch1_addr", cmd_addr_q[b+1], 32'h001C_2000);
        chk("rr_ch2_addr", cmd_addr_q[b+2], 32'h0038_4000);
        chk("rr_ch3_addr", cmd_addr_q[b+3], 32'h0054_6000);
        chk("rr_ch0_again", cmd_addr_q[b+4], 32'h400);

        // frame_start on granted ch3 mid-burst, and on idle ch0 in the same cycle.
        step();
        b = cmd_addr_q.size();
        supply[3] += 64;
        wait_cmds(b + 1, "t3_cmd");
        chk("t3_addr", cmd_addr_q[b], 32'h0054_6400);
        repeat (10) step();
        chk("t3_in_burst", bus.busy, 1'b1);
        bus.frame_start = 4'b1001;
        step();
        bus.frame_start = 4'b0000;
        wait_bursts(8, "t3_done");
        chk("t3_len", len_q[7], 64);
        step();
        supply[0] += 64;
        supply[3] += 64;
        wait_bursts(10, "t3_after");
        chk("t3_ch0_cleared", {cmd_addr_q[b+1], 32'(cmd_ch_q[b+1])}, {32'h0, 32'd0});
        chk("t3_ch3_cleared", {cmd_addr_q[b+2], 32'(cmd_ch_q[b+2])}, {32'h0054_6000, 32'd3});

        // Stalls: wr_ready toggling and FIFO empty mid-burst.
        step();
        ready_mode = 1'b1;
        b = cmd_addr_q.size();
        p0 = popped[1];
        supply[1] += 64;
        wait_cmds(b + 1, "t4_cmd");
        chk("t4_addr", cmd_addr_q[b], 32'h001C_2400);
        repeat (8) step();
        hole[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_empty_no_valid", bus.wr_valid, 1'b0);
        chk("t4_empty_no_rinc", bus.ch_rinc, 4'h0);
        chk("t4_stall_busy", bus.busy, 1'b1);
        step();
        hole[1] = 1'b0;
        wait_bursts(11, "t4_done");
        chk("t4_pops", popped[1] - p0, 64);
        chk("t4_len", len_q[10], 64);
        chk("t4_data_order", data_err, 0);
        ready_mode = 1'b0;

        // Reset after 20 beats of a ch2 burst.
        step();
        p0 = popped[2];
        supply[2] += 64;
        begin
            int c;
            c = 0;
            while (popped[2] - p0 < 20 && c < 500) begin
                @(negedge clk);
                c++;
            end
        end
        chk("t5_reached_beat20", popped[2] - p0, 20);
        #1;
        rrst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {bus.cmd_valid, bus.wr_valid, bus.wr_last, bus.busy}, 4'h0);
        chk("t5_rst_rinc", bus.ch_rinc, 4'h0);
        repeat (3) step();
        chk("t5_no_pop_in_reset", popped[2] - p0, 20);
        rrst_n = 1'b1;
        b = cmd_addr_q.size();
        supply[0] += 64;
        supply[1] += 64;
        supply[3] += 64;
        wait_bursts(14, "t5_after");
        chk("t5_first_ch0", {cmd_addr_q[b], 32'(cmd_ch_q[b])}, {32'h0, 32'd0});
        chk("t5_ch1_offset0", cmd_addr_q[b+1], 32'h001C_2000);
        chk("t5_ch3_offset0", cmd_addr_q[b+2], 32'h0054_6000);
        step();
        supply[2] += 19;
        repeat (5) @(negedge clk);
        chk("t5_63_not_eligible", bus.busy, 1'b0);
        step();
        supply[2] += 1;
        wait_bursts(15, "t5_ch2_done");
        chk("t5_ch2_offset0", cmd_addr_q[b+3], 32'h0038_4000);
        chk("no_illegal_rinc", viol, 0);
        chk("final_data_order", data_err, 0);
        chk("final_last_pos", last_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
